cpri_pkg_arb: RTL and testbench

- Packet-level round-robin arbiter sharing the single write port of the CPRI TX buffer (cpri_tx_gen wen/waddr/wdata/wlast) between NUM_SRC package_data-style sources (per cell / per antenna group).
- Grants whole packets, generates the per-packet write address and enforces length and stall limits.
- Sits between the packers and cpri_tx_gen in the 491.52 MHz domain.

---
 rtl/cpri_pkg_arb_pkg.sv | 24 ++
 rtl/cpri_pkg_arb_if.sv | 26 ++
 rtl/cpri_pkg_arb_rr_pick.sv | 31 +++
 rtl/cpri_pkg_arb.sv | 184 ++++++++++++++++++
 tb/tb_cpri_pkg_arb.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpri_pkg_arb_pkg.sv
// Shared types and constants for the CPRI packet-level write-port arbiter.
package cpri_pkg_arb_pkg;

  localparam int DEF_MAX_LEN = 128;
  localparam int DEF_TMO     = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_DRAIN = 2'd2,
    ST_PAD   = 2'd3
  } state_e;

  // Ceiling log2, floored at 1 so single-entry vectors still get a bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/cpri_pkg_arb_if.sv
// Source handshake plus TX-buffer write bus shared by the packers, the arbiter and cpri_tx_gen.
interface cpri_pkg_arb_if #(
  parameter int NUM_SRC = 4,
  parameter int DW      = 64,
  parameter int AW      = 7
);
  logic [NUM_SRC-1:0]    i_src_vld;
  logic [NUM_SRC-1:0]    i_src_last;
  logic [NUM_SRC*DW-1:0] i_src_data;
  logic [NUM_SRC-1:0]    o_src_rdy;
  logic                  i_buf_afull;
  logic                  o_cpri_wen;
  logic [AW-1:0]         o_cpri_waddr;
  logic [DW-1:0]         o_cpri_wdata;
  logic                  o_cpri_wlast;

  modport master (
    output i_src_vld, i_src_last, i_src_data, i_buf_afull,
    input  o_src_rdy, o_cpri_wen, o_cpri_waddr, o_cpri_wdata, o_cpri_wlast
  );

  modport slave (
    input  i_src_vld, i_src_last, i_src_data, i_buf_afull,
    output o_src_rdy, o_cpri_wen, o_cpri_waddr, o_cpri_wdata, o_cpri_wlast
  );
endinterface

// File: rtl/cpri_pkg_arb_rr_pick.sv
// Combinational round-robin selector: first requester strictly after ptr_i, cyclically.
module rr_pick
  import cpri_pkg_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o
);

  int k;

  // Walk from lowest to highest priority so the nearest requester is written last.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    k     = 0;
    for (int i = N; i >= 1; i--) begin
      k = (int'(ptr_i) + i) % N;
      if (req_i[k]) begin
        gnt_o    = '0;
        gnt_o[k] = 1'b1;
        idx_o    = IW'(k);
      end
    end
  end

endmodule

// File: rtl/cpri_pkg_arb.sv
// Packet-level round-robin arbiter for the CPRI TX buffer write port: grants whole
// packets, numbers words within a packet and enforces length and stall limits.
module cpri_pkg_arb
  import cpri_pkg_arb_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DW      = 64,
  parameter int AW      = 7,
  parameter int MAX_LEN = DEF_MAX_LEN,
  parameter int TMO     = DEF_TMO,
  parameter int IW      = clog2(NUM_SRC)
) (
  input  logic            sys_clk_491_52,
  input  logic            sys_rst_491_52,
  cpri_pkg_arb_if.slave   bus,
  input  logic            i_err_clr,
  output logic [IW-1:0]   o_grant_idx,
  output logic            o_busy,
  output logic            o_err_len,
  output logic            o_err_tmo
);

  localparam int CW = clog2(MAX_LEN + 1);
  localparam int SW = clog2(TMO + 1);

  state_e               state_q, state_d;
  logic [IW-1:0]        ptr_q, ptr_d;
  logic [IW-1:0]        grant_q, grant_d;
  logic [NUM_SRC-1:0]   grant_oh_q, grant_oh_d;
  logic [CW-1:0]        beat_q, beat_d;
  logic [SW-1:0]        stall_q, stall_d;
  logic                 wen_q, wen_d;
  logic [AW-1:0]        waddr_q, waddr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic                 wlast_q, wlast_d;
  logic                 err_len_q, err_len_d;
  logic                 err_tmo_q, err_tmo_d;

  logic [NUM_SRC-1:0]   pick_gnt;
  logic [IW-1:0]        pick_idx;
  logic                 vld_g, last_g, at_max, hit_tmo;
  logic [DW-1:0]        data_g;
  logic [SW-1:0]        stall_inc;

  rr_pick #(.N(NUM_SRC), .IW(IW)) u_pick (
    .req_i (bus.i_src_vld),
    .ptr_i (ptr_q),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx)
  );

  assign vld_g     = bus.i_src_vld[grant_q];
  assign last_g    = bus.i_src_last[grant_q];
  assign data_g    = bus.i_src_data[int'(grant_q)*DW +: DW];
  assign at_max    = (beat_q == CW'(MAX_LEN - 1));
  assign stall_inc = stall_q + SW'(1);
  assign hit_tmo   = (stall_inc == SW'(TMO));

  always_ff @(posedge sys_clk_491_52) begin
    if (sys_rst_491_52) begin
      state_q    <= ST_IDLE;
      ptr_q      <= IW'(NUM_SRC - 1);
      grant_q    <= '0;
      grant_oh_q <= '0;
      beat_q     <= '0;
      stall_q    <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      wlast_q    <= 1'b0;
      err_len_q  <= 1'b0;
      err_tmo_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      grant_q    <= grant_d;
      grant_oh_q <= grant_oh_d;
      beat_q     <= beat_d;
      stall_q    <= stall_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      wlast_q    <= wlast_d;
      err_len_q  <= err_len_d;
      err_tmo_q  <= err_tmo_d;
    end
  end

  // Error flags: a new event in the same cycle as i_err_clr keeps the flag set.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    grant_oh_d = grant_oh_q;
    beat_d     = beat_q;
    stall_d    = stall_q;
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    wlast_d    = 1'b0;
    err_len_d  = err_len_q & ~i_err_clr;
    err_tmo_d  = err_tmo_q & ~i_err_clr;
    unique case (state_q)
      ST_IDLE: begin
        if (|bus.i_src_vld && !bus.i_buf_afull) begin
          state_d    = ST_BURST;
          grant_d    = pick_idx;
          grant_oh_d = pick_gnt;
          beat_d     = '0;
          stall_d    = '0;
        end
      end
      ST_BURST: begin
        if (vld_g) begin
          stall_d = '0;
          beat_d  = beat_q + CW'(1);
          wen_d   = 1'b1;
          waddr_d = AW'(beat_q);
          wdata_d = data_g;
          wlast_d = last_g | at_max;
          if (last_g) begin
            ptr_d   = grant_q;
            state_d = ST_IDLE;
          end else if (at_max) begin
            err_len_d = 1'b1;
            state_d   = ST_DRAIN;
          end
        end else begin
          stall_d = stall_inc;
          if (hit_tmo) begin
            err_tmo_d = 1'b1;
            if (beat_q == '0) begin
              ptr_d   = grant_q;
              state_d = ST_IDLE;
            end else begin
              state_d = ST_PAD;
            end
          end
        end
      end
      ST_DRAIN: begin
        if (vld_g) begin
          stall_d = '0;
          if (last_g) begin
            ptr_d   = grant_q;
            state_d = ST_IDLE;
          end
        end else begin
          stall_d = stall_inc;
          if (hit_tmo) begin
            err_tmo_d = 1'b1;
            ptr_d     = grant_q;
            state_d   = ST_IDLE;
          end
        end
      end
      ST_PAD: begin
        wen_d   = 1'b1;
        waddr_d = AW'(beat_q);
        wdata_d = '0;
        wlast_d = 1'b1;
        ptr_d   = grant_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.o_src_rdy = '0;
    o_busy        = 1'b0;
    if (state_q == ST_BURST || state_q == ST_DRAIN) bus.o_src_rdy = grant_oh_q;
    if (state_q != ST_IDLE) o_busy = 1'b1;
  end

  assign bus.o_cpri_wen   = wen_q;
  assign bus.o_cpri_waddr = waddr_q;
  assign bus.o_cpri_wdata = wdata_q;
  assign bus.o_cpri_wlast = wlast_q;
  assign o_grant_idx      = grant_q;
  assign o_err_len        = err_len_q;
  assign o_err_tmo        = err_tmo_q;

endmodule

// File: tb/tb_cpri_pkg_arb.sv
// Directed bench for cpri_pkg_arb: single packets, round robin, length/stall limits, afull, reset.
module tb_cpri_pkg_arb;
  localparam int NUM_SRC = 4;
  localparam int DW      = 64;
  localparam int AW      = 7;
  localparam int MAX_LEN = 128;
  localparam int TMO     = 255;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       err_clr = 1'b0;
  logic [1:0] grant_idx;
  logic       busy, err_len, err_tmo;
  int         pass_cnt = 0;
  int         fail_cnt = 0;
  int         chk_cnt  = 0;

  cpri_pkg_arb_if #(.NUM_SRC(NUM_SRC), .DW(DW), .AW(AW)) bus ();

  cpri_pkg_arb #(
    .NUM_SRC(NUM_SRC), .DW(DW), .AW(AW), .MAX_LEN(MAX_LEN), .TMO(TMO)
  ) dut (
    .sys_clk_491_52 (clk),
    .sys_rst_491_52 (rst),
    .bus            (bus),
    .i_err_clr      (err_clr),
    .o_grant_idx    (grant_idx),
    .o_busy         (busy),
    .o_err_len      (err_len),
    .o_err_tmo      (err_tmo)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] mkdat(input int s, input int w);
    return {8'(8'hA0 + s), 24'h0, 32'(w)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive1(input int s, input int w, input logic lst);
    bus.i_src_vld  = 4'(1 << s);
    bus.i_src_last = lst ? 4'(1 << s) : 4'b0000;
    bus.i_src_data = '0;
    bus.i_src_data[s*DW +: DW] = mkdat(s, w);
  endtask

  task automatic idle_src();
    bus.i_src_vld  = '0;
    bus.i_src_last = '0;
  endtask

  int               cnt [NUM_SRC];
  logic [NUM_SRC-1:0] r;
  logic             any_wen;
  int               pkt, ph, s;

  initial begin
    bus.i_src_vld   = '0;
    bus.i_src_last  = '0;
    bus.i_src_data  = '0;
    bus.i_buf_afull = 1'b0;
    repeat (3) tick();

    // Reset state
    chk1("rst_wen", bus.o_cpri_wen, 1'b0);
    chk1("rst_wlast", bus.o_cpri_wlast, 1'b0);
    chkv("rst_waddr", 64'(bus.o_cpri_waddr), 64'(0));
    chkv("rst_rdy", 64'(bus.o_src_rdy), 64'(0));
    chkv("rst_grant", 64'(grant_idx), 64'(0));
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_err_len", err_len, 1'b0);
    chk1("rst_err_tmo", err_tmo, 1'b0);
    rst = 1'b0;

    // Source 0, 10-word packet
    drive1(0, 0, 1'b0);
    tick();
    chk1("t1_busy", busy, 1'b1);
    chkv("t1_rdy", 64'(bus.o_src_rdy), 64'(1));
    chk1("t1_grant_nowen", bus.o_cpri_wen, 1'b0);
    for (int w = 0; w < 10; w++) begin
      drive1(0, w, w == 9);
      tick();
      chk1("t1_wen", bus.o_cpri_wen, 1'b1);
      chkv("t1_waddr", 64'(bus.o_cpri_waddr), 64'(w));
      chkv("t1_wdata", bus.o_cpri_wdata, mkdat(0, w));
      chk1("t1_wlast", bus.o_cpri_wlast, w == 9);
      chkv("t1_grant", 64'(grant_idx), 64'(0));
    end
    idle_src();
    tick();
    chk1("t1_wen_off", bus.o_cpri_wen, 1'b0);
    chk1("t1_busy_off", busy, 1'b0);

    // All sources, 4-word packets, round robin from source 0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) cnt[k] = 0;
    for (int c = 0; c < 25; c++) begin
      for (int k = 0; k < NUM_SRC; k++) begin
        bus.i_src_vld[k]  = 1'b1;
        bus.i_src_last[k] = (cnt[k] % 4) == 3;
        bus.i_src_data[k*DW +: DW] = mkdat(k, cnt[k]);
      end
      r = bus.o_src_rdy;
      tick();
      for (int k = 0; k < NUM_SRC; k++) if (r[k]) cnt[k]++;
      pkt = c / 5;
      ph  = c % 5;
      s   = pkt % 4;
      chk1("t2_onehot", $onehot0(bus.o_src_rdy), 1'b1);
      chkv("t2_grant", 64'(grant_idx), 64'(s));
      if (ph == 0) begin
        chk1("t2_gap_wen", bus.o_cpri_wen, 1'b0);
        chkv("t2_rdy_grant", 64'(bus.o_src_rdy), 64'(1 << s));
      end else begin
        chk1("t2_wen", bus.o_cpri_wen, 1'b1);
        chkv("t2_waddr", 64'(bus.o_cpri_waddr), 64'(ph - 1));
        chkv("t2_wdata", bus.o_cpri_wdata, mkdat(s, (pkt / 4) * 4 + ph - 1));
        chk1("t2_wlast", bus.o_cpri_wlast, ph == 4);
        chkv("t2_rdy", 64'(bus.o_src_rdy), (ph == 4) ? 64'(0) : 64'(1 << s));
      end
    end
    idle_src();

    // Source 2, 130 words: forced wlast at 127, words 128..129 drained
    drive1(2, 0, 1'b0);
    tick();
    chkv("t3_grant", 64'(grant_idx), 64'(2));
    for (int w = 0; w < 130; w++) begin
      drive1(2, w, w == 129);
      r = bus.o_src_rdy;
      tick();
      chkv("t3_rdy", 64'(r), 64'(4));
      if (w < 128) begin
        chk1("t3_wen", bus.o_cpri_wen, 1'b1);
        chkv("t3_waddr", 64'(bus.o_cpri_waddr), 64'(w));
        chkv("t3_wdata", bus.o_cpri_wdata, mkdat(2, w));
        chk1("t3_wlast", bus.o_cpri_wlast, w == 127);
        chk1("t3_err_len", err_len, w >= 127);
      end else begin
        chk1("t3_drop_wen", bus.o_cpri_wen, 1'b0);
        chk1("t3_drain_busy", busy, w == 128);
      end
    end
    drive1(3, 0, 1'b0);
    tick();
    chkv("t3_next_grant", 64'(grant_idx), 64'(3));
    tick();
    chkv("t3_next_waddr0", 64'(bus.o_cpri_waddr), 64'(0));
    chk1("t3_next_wen0", bus.o_cpri_wen, 1'b1);
    drive1(3, 1, 1'b1);
    tick();
    chkv("t3_next_waddr1", 64'(bus.o_cpri_waddr), 64'(1));
    chk1("t3_next_wlast", bus.o_cpri_wlast, 1'b1);
    idle_src();

    // Source 1: 3 words then stall until timeout, pad word follows
    drive1(1, 0, 1'b0);
    tick();
    chkv("t4_grant", 64'(grant_idx), 64'(1));
    for (int w = 0; w < 3; w++) begin
      drive1(1, w, 1'b0);
      tick();
      chk1("t4_wen", bus.o_cpri_wen, 1'b1);
      chkv("t4_waddr", 64'(bus.o_cpri_waddr), 64'(w));
    end
    idle_src();
    any_wen = 1'b0;
    for (int i = 1; i < TMO; i++) begin
      tick();
      any_wen = any_wen | bus.o_cpri_wen;
    end
    chk1("t4_stall_nowen", any_wen, 1'b0);
    chk1("t4_tmo_early", err_tmo, 1'b0);
    chk1("t4_stall_busy", busy, 1'b1);
    tick();
    chk1("t4_err_tmo", err_tmo, 1'b1);
    chk1("t4_pad_busy", busy, 1'b1);
    chk1("t4_pre_pad_wen", bus.o_cpri_wen, 1'b0);
    tick();
    chk1("t4_pad_wen", bus.o_cpri_wen, 1'b1);
    chkv("t4_pad_waddr", 64'(bus.o_cpri_waddr), 64'(3));
    chkv("t4_pad_wdata", bus.o_cpri_wdata, 64'(0));
    chk1("t4_pad_wlast", bus.o_cpri_wlast, 1'b1);
    chk1("t4_idle", busy, 1'b0);

    // Buffer almost full blocks grants; release grants on the next edge
    bus.i_buf_afull = 1'b1;
    bus.i_src_vld   = '1;
    bus.i_src_last  = '1;
    for (int k = 0; k < NUM_SRC; k++) bus.i_src_data[k*DW +: DW] = mkdat(k, 50);
    for (int i = 0; i < 5; i++) begin
      tick();
      chkv("t5_afull_rdy", 64'(bus.o_src_rdy), 64'(0));
      chk1("t5_afull_wen", bus.o_cpri_wen, 1'b0);
      chk1("t5_afull_busy", busy, 1'b0);
    end
    bus.i_buf_afull = 1'b0;
    tick();
    chk1("t5_grant_busy", busy, 1'b1);
    chkv("t5_grant", 64'(grant_idx), 64'(2));
    chkv("t5_rdy", 64'(bus.o_src_rdy), 64'(4));
    tick();
    idle_src();
    chk1("t5_wen", bus.o_cpri_wen, 1'b1);
    chkv("t5_waddr", 64'(bus.o_cpri_waddr), 64'(0));
    chk1("t5_wlast", bus.o_cpri_wlast, 1'b1);
    chkv("t5_wdata", bus.o_cpri_wdata, mkdat(2, 50));
    chk1("t5_len_sticky", err_len, 1'b1);
    chk1("t5_tmo_sticky", err_tmo, 1'b1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk1("t5_len_clr", err_len, 1'b0);
    chk1("t5_tmo_clr", err_tmo, 1'b0);

    // Reset at beat 5 of a source-3 packet
    drive1(3, 0, 1'b0);
    tick();
    chkv("t6_grant", 64'(grant_idx), 64'(3));
    for (int w = 0; w < 5; w++) begin
      drive1(3, w, 1'b0);
      tick();
      chkv("t6_waddr", 64'(bus.o_cpri_waddr), 64'(w));
    end
    drive1(3, 5, 1'b0);
    rst = 1'b1;
    tick();
    chk1("t6_rst_wen", bus.o_cpri_wen, 1'b0);
    chk1("t6_rst_wlast", bus.o_cpri_wlast, 1'b0);
    chkv("t6_rst_waddr", 64'(bus.o_cpri_waddr), 64'(0));
    chkv("t6_rst_wdata", bus.o_cpri_wdata, 64'(0));
    chkv("t6_rst_grant", 64'(grant_idx), 64'(0));
    chk1("t6_rst_busy", busy, 1'b0);
    chkv("t6_rst_rdy", 64'(bus.o_src_rdy), 64'(0));
    rst = 1'b0;
    bus.i_src_vld  = 4'b1001;
    bus.i_src_last = 4'b1001;
    bus.i_src_data = '0;
    bus.i_src_data[0 +: DW] = mkdat(0, 0);
    bus.i_src_data[3*DW +: DW] = mkdat(3, 6);
    tick();
    chkv("t6_regrant", 64'(grant_idx), 64'(0));
    chkv("t6_regrant_rdy", 64'(bus.o_src_rdy), 64'(1));
    tick();
    idle_src();
    chk1("t6_wen", bus.o_cpri_wen, 1'b1);
    chkv("t6_wdata", bus.o_cpri_wdata, mkdat(0, 0));
    chkv("t6_waddr", 64'(bus.o_cpri_waddr), 64'(0));
    chk1("t6_wlast", bus.o_cpri_wlast, 1'b1);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
